io_cpx_req_sched: RTL and testbench

- Sequences IO-block return packets onto the CPX.
- Queues destination vectors from the IO packet source and drives per-core `io_cpx_req_cq` requests.
- Consumes `cpx_io_grant_ca` grants to keep at most MAX_OUT ungranted requests per core.
- Sits between the IO packet queue and the IO-side CPX buffer: `io_cpx_req_cq` feeds the buffer inverter; `cpx_io_grant_ca` is the buffered grant.

---
 rtl/io_cpx_req_sched.sv | 137 +++++++++++++
 tb/tb_io_cpx_req_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_cpx_req_sched.sv
// io_cpx_req_sched: queues IO return-packet destination vectors and issues per-core CPX
// requests under a per-core credit limit. Define IO_CPX_REQ_TIMEOUT_EN for the ungranted-request watchdog.
module io_cpx_req_sched #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2,
    parameter int TIMEOUT = 255
) (
    input  logic       rclk,
    input  logic       reset,
    input  logic       enq_vld,
    input  logic [7:0] enq_dest,
    output logic       enq_rdy,
    output logic [7:0] io_cpx_req_cq,
    input  logic [7:0] cpx_io_grant_ca,
    output logic       pkt_issue,
    output logic [7:0] out_cnt_nz,
    output logic       grant_err,
    output logic       timeout_err
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [1:0]  CMAX     = 2'(MAX_OUT);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (MAX_OUT < 1 || MAX_OUT > 3) begin : g_chk_max_out
        $error("MAX_OUT must be in 1..3");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_chk_timeout
        $error("TIMEOUT must be in 1..255");
    end

    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic [1:0]    cnt      [8];
    logic [1:0]    cnt_next [8];
    logic [7:0]    head;
    logic [7:0]    spurious;
    logic [7:0]    nz_next;
    logic          full;
    logic          empty;
    logic          enq_fire;
    logic          issue;

    assign head     = fifo_mem[rd_ptr];
    assign empty    = (occ == '0);
    assign full     = (occ == OCC_FULL);
    assign enq_rdy  = !full;
    assign enq_fire = enq_vld && !full && (enq_dest != 8'h00);

    // A multi-hot head issues only when every addressed core has a free credit
    always_comb begin
        issue = !empty;
        for (int i = 0; i < 8; i++) begin
            if (head[i] && (cnt[i] >= CMAX)) issue = 1'b0;
        end
    end

    always_comb begin
        spurious = '0;
        nz_next  = '0;
        for (int i = 0; i < 8; i++) begin
            cnt_next[i] = cnt[i];
            if (issue && head[i]) cnt_next[i] = cnt_next[i] + 2'd1;
            if (cpx_io_grant_ca[i]) begin
                if (cnt[i] == 2'd0) spurious[i] = 1'b1;
                else                cnt_next[i] = cnt_next[i] - 2'd1;
            end
            nz_next[i] = (cnt_next[i] != 2'd0);
        end
    end

    always_ff @(posedge rclk) begin
        if (enq_fire) fifo_mem[wr_ptr] <= enq_dest;
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            io_cpx_req_cq <= '0;
            pkt_issue     <= 1'b0;
            out_cnt_nz    <= '0;
            grant_err     <= 1'b0;
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + AW'(1);
            if (issue)    rd_ptr <= rd_ptr + AW'(1);
            case ({enq_fire, issue})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
            io_cpx_req_cq <= issue ? head : 8'h00;
            pkt_issue     <= issue;
            out_cnt_nz    <= nz_next;
            grant_err     <= grant_err | (|spurious);
            for (int i = 0; i < 8; i++) cnt[i] <= cnt_next[i];
        end
    end

`ifdef IO_CPX_REQ_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    logic [7:0] age      [8];
    logic [7:0] age_next [8];
    logic       age_hit;

    // Age restarts on an idle core or any grant, so it measures time since the last credit return
    always_comb begin
        age_hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((cnt[i] == 2'd0) || cpx_io_grant_ca[i]) age_next[i] = '0;
            else if (age[i] != 8'hFF)                   age_next[i] = age[i] + 8'd1;
            else                                        age_next[i] = age[i];
            if (age_next[i] >= TO_LIM) age_hit = 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            timeout_err <= 1'b0;
            for (int i = 0; i < 8; i++) age[i] <= '0;
        end else begin
            timeout_err <= timeout_err | age_hit;
            for (int i = 0; i < 8; i++) age[i] <= age_next[i];
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_io_cpx_req_sched.sv
// Self-checking bench for io_cpx_req_sched: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_io_cpx_req_sched;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;
    localparam int TIMEOUT = 20;

    logic       rclk = 1'b0;
    logic       reset = 1'b1;
    logic       enq_vld = 1'b0;
    logic [7:0] enq_dest = 8'h00;
    logic [7:0] cpx_io_grant_ca = 8'h00;
    logic       enq_rdy;
    logic [7:0] io_cpx_req_cq;
    logic       pkt_issue;
    logic [7:0] out_cnt_nz;
    logic       grant_err;
    logic       timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    io_cpx_req_sched #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
        .rclk            (rclk),
        .reset           (reset),
        .enq_vld         (enq_vld),
        .enq_dest        (enq_dest),
        .enq_rdy         (enq_rdy),
        .io_cpx_req_cq   (io_cpx_req_cq),
        .cpx_io_grant_ca (cpx_io_grant_ca),
        .pkt_issue       (pkt_issue),
        .out_cnt_nz      (out_cnt_nz),
        .grant_err       (grant_err),
        .timeout_err     (timeout_err)
    );

    always #5 rclk = ~rclk;

    // Reference model: pending destinations in a queue, outstanding credits per core
    logic [7:0] m_q[$];
    int         m_cnt[8];
    logic [7:0] m_req;
    logic       m_pi;
    logic       m_gerr;

    function automatic logic [7:0] m_nz();
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i] = (m_cnt[i] != 0);
        return r;
    endfunction

    task automatic m_reset();
        m_q.delete();
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_req  = '0;
        m_pi   = 1'b0;
        m_gerr = 1'b0;
    endtask

    task automatic m_step(input logic v, input logic [7:0] d, input logic [7:0] g);
        logic       ok;
        logic       can_enq;
        logic [7:0] hd;
        hd      = '0;
        can_enq = v && (d != 8'h00) && (m_q.size() < DEPTH);
        ok      = (m_q.size() > 0);
        if (ok) begin
            hd = m_q[0];
            for (int i = 0; i < 8; i++) if (hd[i] && m_cnt[i] >= MAX_OUT) ok = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            if (g[i]) begin
                if (m_cnt[i] == 0) m_gerr = 1'b1;
                else               m_cnt[i]--;
            end
        end
        m_req = ok ? hd : 8'h00;
        m_pi  = ok;
        if (ok) begin
            void'(m_q.pop_front());
            for (int i = 0; i < 8; i++) if (hd[i]) m_cnt[i]++;
        end
        if (can_enq) m_q.push_back(d);
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic [7:0] g);
        enq_vld         = v;
        enq_dest        = d;
        cpx_io_grant_ca = g;
        m_step(v, d, g);
        @(posedge rclk);
        #1;
        enq_vld         = 1'b0;
        enq_dest        = 8'h00;
        cpx_io_grant_ca = 8'h00;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        enq_vld         = 1'b0;
        enq_dest        = 8'h00;
        cpx_io_grant_ca = 8'h00;
        repeat (2) @(posedge rclk);
        #1;
        reset = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (io_cpx_req_cq !== 8'h00) begin n_err++; $display("FAIL reset_req got=%h exp=00", io_cpx_req_cq); end
        n_cmp++; if (pkt_issue !== 1'b0) begin n_err++; $display("FAIL reset_pkt_issue got=%b exp=0", pkt_issue); end
        n_cmp++; if (out_cnt_nz !== 8'h00) begin n_err++; $display("FAIL reset_nz got=%h exp=00", out_cnt_nz); end
        n_cmp++; if (grant_err !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_errs got=%b%b exp=00", grant_err, timeout_err); end
        n_cmp++; if (enq_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy got=%b exp=1", enq_rdy); end
    endtask

    task automatic test_single();
        do_reset();
        cyc(1'b1, 8'h01, 8'h00);
        n_cmp++; if (io_cpx_req_cq !== 8'h00 || pkt_issue !== 1'b0) begin n_err++; $display("FAIL single_c1 got=%h/%b exp=00/0", io_cpx_req_cq, pkt_issue); end
        cyc(1'b0, 8'h00, 8'h00);
        n_cmp++; if (io_cpx_req_cq !== 8'h01 || pkt_issue !== 1'b1) begin n_err++; $display("FAIL single_c2 got=%h/%b exp=01/1", io_cpx_req_cq, pkt_issue); end
        n_cmp++; if (out_cnt_nz !== 8'h01) begin n_err++; $display("FAIL single_nz_c2 got=%h exp=01", out_cnt_nz); end
        cyc(1'b0, 8'h00, 8'h00);
        n_cmp++; if (io_cpx_req_cq !== 8'h00 || pkt_issue !== 1'b0 || out_cnt_nz !== 8'h01) begin n_err++; $display("FAIL single_c3 got=%h/%b/%h exp=00/0/01", io_cpx_req_cq, pkt_issue, out_cnt_nz); end
        cyc(1'b0, 8'h00, 8'h00);
        cyc(1'b0, 8'h00, 8'h01);
        n_cmp++; if (out_cnt_nz !== 8'h00 || grant_err !== 1'b0) begin n_err++; $display("FAIL single_c5 got=%h/%b exp=00/0", out_cnt_nz, grant_err); end
    endtask

    task automatic test_credit_hold();
        logic [7:0] exp_req;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cyc(k < 3, (k < 3) ? 8'h04 : 8'h00, (k == 6) ? 8'h04 : 8'h00);
            exp_req = (k + 1 == 2 || k + 1 == 3 || k + 1 == 8) ? 8'h04 : 8'h00;
            n_cmp++; if (io_cpx_req_cq !== exp_req) begin n_err++; $display("FAIL credit_hold c%0d got=%h exp=%h", k + 1, io_cpx_req_cq, exp_req); end
        end
    endtask

    task automatic test_broadcast();
        logic [7:0] exp_req;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cyc(k < 3, (k < 2) ? 8'h08 : ((k == 2) ? 8'hFF : 8'h00), (k == 7) ? 8'h08 : 8'h00);
            exp_req = (k + 1 == 2 || k + 1 == 3) ? 8'h08 : ((k + 1 == 9) ? 8'hFF : 8'h00);
            n_cmp++; if (io_cpx_req_cq !== exp_req) begin n_err++; $display("FAIL broadcast c%0d got=%h exp=%h", k + 1, io_cpx_req_cq, exp_req); end
        end
        n_cmp++; if (out_cnt_nz !== 8'hFF) begin n_err++; $display("FAIL broadcast_nz got=%h exp=ff", out_cnt_nz); end
    endtask

    task automatic test_fill();
        logic [7:0] exp_req;
        int         c;
        do_reset();
        for (int k = 0; k < 15; k++) begin
            c = k + 1;
            cyc(k < 7, (k < 6) ? 8'h01 : ((k == 6) ? 8'h02 : 8'h00), (k >= 7 && k <= 12) ? 8'h01 : 8'h00);
            exp_req = (c == 2 || c == 3 || (c >= 9 && c <= 12)) ? 8'h01 : 8'h00;
            n_cmp++; if (io_cpx_req_cq !== exp_req) begin n_err++; $display("FAIL fill_req c%0d got=%h exp=%h", c, io_cpx_req_cq, exp_req); end
            if (c == 6) begin
                n_cmp++; if (enq_rdy !== 1'b0) begin n_err++; $display("FAIL fill_full_rdy got=%b exp=0", enq_rdy); end
            end
            if (c == 9) begin
                n_cmp++; if (enq_rdy !== 1'b1) begin n_err++; $display("FAIL fill_rdy_back got=%b exp=1", enq_rdy); end
            end
        end
        n_cmp++; if (out_cnt_nz !== 8'h00 || grant_err !== 1'b0) begin n_err++; $display("FAIL fill_end got=%h/%b exp=00/0", out_cnt_nz, grant_err); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_req;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cyc(k < 4, (k < 4) ? 8'(1 << k) : 8'h00, 8'h00);
            exp_req = (k + 1 >= 2 && k + 1 <= 5) ? 8'(1 << (k - 1)) : 8'h00;
            n_cmp++; if (io_cpx_req_cq !== exp_req || pkt_issue !== (exp_req != 8'h00)) begin n_err++; $display("FAIL b2b c%0d got=%h/%b exp=%h", k + 1, io_cpx_req_cq, pkt_issue, exp_req); end
        end
    endtask

    task automatic test_grant_err();
        do_reset();
        cyc(1'b0, 8'h00, 8'h10);
        n_cmp++; if (grant_err !== 1'b1 || out_cnt_nz !== 8'h00) begin n_err++; $display("FAIL grant_err_set got=%b/%h exp=1/00", grant_err, out_cnt_nz); end
        repeat (5) cyc(1'b0, 8'h00, 8'h00);
        n_cmp++; if (grant_err !== 1'b1) begin n_err++; $display("FAIL grant_err_sticky got=%b exp=1", grant_err); end
        do_reset();
        n_cmp++; if (grant_err !== 1'b0) begin n_err++; $display("FAIL grant_err_clear got=%b exp=0", grant_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (3) cyc(1'b1, 8'h01, 8'h00);
        cyc(1'b0, 8'h00, 8'h00);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 8'h00, 8'h00);
            n_cmp++; if (io_cpx_req_cq !== 8'h00 || out_cnt_nz !== 8'h00) begin n_err++; $display("FAIL reset_mid c%0d got=%h/%h exp=00/00", k + 1, io_cpx_req_cq, out_cnt_nz); end
        end
        cyc(1'b0, 8'h00, 8'h01);
        n_cmp++; if (grant_err !== 1'b1) begin n_err++; $display("FAIL reset_mid_grant got=%b exp=1", grant_err); end
    endtask

    task automatic test_timeout();
        logic exp_to;
        do_reset();
        cyc(1'b1, 8'h01, 8'h00);
        cyc(1'b0, 8'h00, 8'h00);
        for (int c = 3; c <= 30; c++) begin
            cyc(1'b0, 8'h00, 8'h00);
`ifdef IO_CPX_REQ_TIMEOUT_EN
            exp_to = (c >= 2 + TIMEOUT);
`else
            exp_to = 1'b0;
`endif
            n_cmp++; if (timeout_err !== exp_to) begin n_err++; $display("FAIL timeout c%0d got=%b exp=%b", c, timeout_err, exp_to); end
        end
    endtask

    task automatic test_random();
        logic       v;
        logic [7:0] d;
        logic [7:0] g;
        int         r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset();
            v = ($urandom_range(3) != 0);
            r = $urandom_range(7);
            d = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : (r < 5) ? 8'(1 << $urandom_range(7)) : 8'($urandom);
            g = '0;
            for (int i = 0; i < 8; i++) if (m_cnt[i] > 0 && $urandom_range(2) == 0) g[i] = 1'b1;
            if ($urandom_range(63) == 0) g[$urandom_range(7)] = 1'b1;
            cyc(v, d, g);
            n_cmp++; if (io_cpx_req_cq !== m_req || pkt_issue !== m_pi) begin n_err++; $display("FAIL rand_req c%0d got=%h/%b exp=%h/%b", c, io_cpx_req_cq, pkt_issue, m_req, m_pi); end
            n_cmp++; if (out_cnt_nz !== m_nz()) begin n_err++; $display("FAIL rand_nz c%0d got=%h exp=%h", c, out_cnt_nz, m_nz()); end
            n_cmp++; if (enq_rdy !== (m_q.size() < DEPTH)) begin n_err++; $display("FAIL rand_rdy c%0d got=%b exp=%b", c, enq_rdy, m_q.size() < DEPTH); end
            n_cmp++; if (grant_err !== m_gerr) begin n_err++; $display("FAIL rand_gerr c%0d got=%b exp=%b", c, grant_err, m_gerr); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_credit_hold();
        test_broadcast();
        test_fill();
        test_back_to_back();
        test_grant_err();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
